// File: rtl/tour_cmd.sv
// rtl/tour_cmd.sv - replays solver knight's-tour moves as command-processor commands
module tour_cmd #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] VERT  = 3'd2;
    localparam logic [2:0] VWAIT = 3'd3;
    localparam logic [2:0] HORZ  = 3'd4;
    localparam logic [2:0] HWAIT = 3'd5;

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    logic [2:0]  state;
    logic [7:0]  move_reg;
    logic        move_one_hot;
    logic        dy_pos, dy_two, dx_pos, dx_two;
    logic [15:0] vert_cmd, horz_cmd;

    // Zero is rejected as well as multi-bit moves.
    assign move_one_hot = (move != 8'h00) && ((move & (move - 8'h01)) == 8'h00);

    // Group the eight L-moves by direction and length of each leg.
    assign dy_pos = |(move_reg & 8'b1000_0111);
    assign dy_two = |(move_reg & 8'b0011_0011);
    assign dx_pos = |(move_reg & 8'b1110_0001);
    assign dx_two = |(move_reg & 8'b1100_1100);

    assign vert_cmd = {4'b0010, (dy_pos ? 8'h00 : 8'h7F), (dy_two ? 4'd2 : 4'd1)};
    assign horz_cmd = {4'b0011, (dx_pos ? 8'hBF : 8'h3F), (dx_two ? 4'd2 : 4'd1)};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mv_indx  <= 5'd0;
            move_reg <= 8'h00;
            tour_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_tour) begin
                        mv_indx  <= 5'd0;
                        tour_err <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    move_reg <= move;
                    if (move_one_hot) begin
                        state <= VERT;
                    end else begin
                        tour_err <= 1'b1;
                        state    <= IDLE;
                    end
                end
                VERT: if (clr_cmd_rdy) state <= VWAIT;
                VWAIT: if (send_resp) state <= HORZ;
                HORZ: if (clr_cmd_rdy) state <= HWAIT;
                HWAIT: begin
                    if (send_resp) begin
                        if (mv_indx == LAST_IDX) begin
                            state <= IDLE;
                        end else begin
                            mv_indx <= mv_indx + 5'd1;
                            state   <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cmd              = vert_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = 8'hA5;
        case (state)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
            end
            VERT: cmd_rdy = 1'b1;
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
            end
            HWAIT: begin
                cmd = horz_cmd;
                if (mv_indx == LAST_IDX) resp = 8'h5A;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// tb/tb_tour_cmd.sv - randomized self-checking bench for tour_cmd
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;
    logic        tour_err;

    logic [7:0] mem [0:31];
    int dx_tab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dy_tab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    int vectors = 0;
    int miscompares = 0;

    assign move = mem[mv_indx];

    always #5 clk = ~clk;

    tour_cmd #(.NUM_MOVES(24)) dut (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
        .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
        .tour_err(tour_err)
    );

    function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input bit horiz);
        int k = 0;
        int d;
        for (int i = 0; i < 8; i++) if (mv[i]) k = i;
        if (horiz) begin
            d = dx_tab[k];
            return {4'h3, (d > 0) ? 8'hBF : 8'h3F, 4'((d < 0) ? -d : d)};
        end
        d = dy_tab[k];
        return {4'h2, (d > 0) ? 8'h00 : 8'h7F, 4'((d < 0) ? -d : d)};
    endfunction

    function automatic logic [7:0] rand_move();
        return 8'h01 << $urandom_range(7, 0);
    endfunction

    task automatic serve_leg(input logic [15:0] exp_cmd, input logic [7:0] exp_resp,
                             input bit no_resp);
        int t = 0;
        #1;
        while (cmd_rdy !== 1'b1 && t < 20) begin
            @(negedge clk); #1; t++;
        end
        vectors++;
        if (cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL leg_timeout: cmd_rdy=%b required 1 for cmd %h", cmd_rdy, exp_cmd);
            return;
        end
        vectors++;
        if (cmd !== exp_cmd) begin
            miscompares++;
            $display("FAIL leg_cmd: cmd=%h required %h (mv_indx=%0d)", cmd, exp_cmd, mv_indx);
        end
        if ($urandom_range(1, 0) == 1) begin
            send_resp = 1'b1;
            @(negedge clk); send_resp = 1'b0; #1;
            vectors++;
            if (cmd_rdy !== 1'b1 || cmd !== exp_cmd) begin
                miscompares++;
                $display("FAIL early_resp_ignored: cmd_rdy=%b cmd=%h required 1 %h", cmd_rdy, cmd, exp_cmd);
            end
        end
        clr_cmd_rdy = 1'b1; #1;
        vectors++;
        if (clr_cmd_rdy_UART !== 1'b0) begin
            miscompares++;
            $display("FAIL uart_clr_blocked: clr_cmd_rdy_UART=%b required 0", clr_cmd_rdy_UART);
        end
        @(negedge clk); clr_cmd_rdy = 1'b0; #1;
        vectors++;
        if (cmd_rdy !== 1'b0 || resp !== exp_resp) begin
            miscompares++;
            $display("FAIL leg_wait: cmd_rdy=%b resp=%h required 0 %h", cmd_rdy, resp, exp_resp);
        end
        if (no_resp) return;
        repeat ($urandom_range(3, 0)) @(negedge clk);
        if ($urandom_range(1, 0) == 1) begin
            clr_cmd_rdy = 1'b1;
            @(negedge clk); clr_cmd_rdy = 1'b0;
        end
        send_resp = 1'b1;
        @(negedge clk); send_resp = 1'b0;
    endtask

    task automatic serve_moves(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            serve_leg(leg_cmd(mem[i], 1'b0), 8'hA5, 1'b0);
            serve_leg(leg_cmd(mem[i], 1'b1), (i == 23) ? 8'h5A : 8'hA5, 1'b0);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start_tour = 1'b1;
        @(negedge clk); start_tour = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cmd_UART = 16'($urandom);
        cmd_rdy_UART = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (mv_indx !== 5'd0 || tour_err !== 1'b0 || resp !== 8'hA5) begin
            miscompares++;
            $display("FAIL reset_regs: mv_indx=%0d tour_err=%b resp=%h required 0 0 a5", mv_indx, tour_err, resp);
        end
        vectors++;
        if (cmd !== cmd_UART || cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_passthru: cmd=%h cmd_rdy=%b required %h 1", cmd, cmd_rdy, cmd_UART);
        end
        rst_n = 1'b1;
        cmd_rdy_UART = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        cmd_UART = 16'h2001; cmd_rdy_UART = 1'b1; #1;
        vectors++;
        if (cmd !== 16'h2001 || cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL passthru_2001: cmd=%h cmd_rdy=%b required 2001 1", cmd, cmd_rdy);
        end
        clr_cmd_rdy = 1'b1; #1;
        vectors++;
        if (clr_cmd_rdy_UART !== 1'b1) begin
            miscompares++;
            $display("FAIL passthru_clr: clr_cmd_rdy_UART=%b required 1", clr_cmd_rdy_UART);
        end
        @(negedge clk); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [15:0] c = 16'($urandom);
            logic r = 1'($urandom);
            logic k = 1'($urandom);
            cmd_UART = c; cmd_rdy_UART = r; clr_cmd_rdy = k; #1;
            vectors++;
            if (cmd !== c || cmd_rdy !== r || clr_cmd_rdy_UART !== k) begin
                miscompares++;
                $display("FAIL passthru_rand: cmd=%h rdy=%b clr=%b required %h %b %b", cmd, cmd_rdy, clr_cmd_rdy_UART, c, r, k);
            end
            @(negedge clk);
        end
        clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_full_tour();
        for (int i = 0; i < 32; i++) mem[i] = rand_move();
        mem[0] = 8'h01; mem[1] = 8'h08; mem[2] = 8'h10; mem[3] = 8'h40;
        pulse_start();
        #1;
        vectors++;
        if (cmd_rdy !== 1'b0 || mv_indx !== 5'd0) begin
            miscompares++;
            $display("FAIL start_load: cmd_rdy=%b mv_indx=%0d required 0 0", cmd_rdy, mv_indx);
        end
        @(negedge clk); #1;
        vectors++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'h2002) begin
            miscompares++;
            $display("FAIL start_latency: cmd_rdy=%b cmd=%h required 1 2002", cmd_rdy, cmd);
        end
        @(negedge clk);
        serve_moves(0, 23);
        #1;
        vectors++;
        if (mv_indx !== 5'd23 || tour_err !== 1'b0 || cmd_rdy !== 1'b0 || cmd !== cmd_UART) begin
            miscompares++;
            $display("FAIL tour_end: mv_indx=%0d err=%b cmd_rdy=%b cmd=%h required 23 0 0 %h", mv_indx, tour_err, cmd_rdy, cmd, cmd_UART);
        end
        @(negedge clk);
    endtask

    task automatic test_bad_move();
        logic [7:0] bad_tab [3] = '{8'h03, 8'h00, 8'h81};
        for (int i = 0; i < 32; i++) mem[i] = rand_move();
        mem[5] = 8'h03;
        pulse_start();
        serve_moves(0, 4);
        #1;
        @(negedge clk); #1;
        vectors++;
        if (tour_err !== 1'b1 || mv_indx !== 5'd5 || cmd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_move: tour_err=%b mv_indx=%0d cmd_rdy=%b required 1 5 0", tour_err, mv_indx, cmd_rdy);
        end
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (cmd_rdy !== 1'b0 || tour_err !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_move_quiet: cmd_rdy=%b tour_err=%b required 0 1", cmd_rdy, tour_err);
        end
        mem[0] = bad_tab[$urandom_range(2, 0)];
        pulse_start();
        #1;
        vectors++;
        if (tour_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_cleared: tour_err=%b required 0", tour_err);
        end
        @(negedge clk); #1;
        vectors++;
        if (tour_err !== 1'b1 || cmd_rdy !== 1'b0 || mv_indx !== 5'd0) begin
            miscompares++;
            $display("FAIL bad_first: tour_err=%b cmd_rdy=%b mv_indx=%0d required 1 0 0", tour_err, cmd_rdy, mv_indx);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_tour();
        for (int i = 0; i < 32; i++) mem[i] = rand_move();
        pulse_start();
        cmd_UART = 16'h2001; cmd_rdy_UART = 1'b1;
        serve_moves(0, 9);
        serve_leg(leg_cmd(mem[10], 1'b0), 8'hA5, 1'b1);
        vectors++;
        if (mv_indx !== 5'd10) begin
            miscompares++;
            $display("FAIL pre_reset_indx: mv_indx=%0d required 10", mv_indx);
        end
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        vectors++;
        if (mv_indx !== 5'd0 || cmd_rdy !== 1'b1 || cmd !== 16'h2001) begin
            miscompares++;
            $display("FAIL reset_mid_tour: mv_indx=%0d cmd_rdy=%b cmd=%h required 0 1 2001", mv_indx, cmd_rdy, cmd);
        end
        cmd_rdy_UART = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            vectors++;
            if (cmd_rdy !== 1'b0 || cmd !== cmd_UART) begin
                miscompares++;
                $display("FAIL post_reset_idle: cmd_rdy=%b cmd=%h required 0 %h", cmd_rdy, cmd, cmd_UART);
            end
        end
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 32; i++) mem[i] = rand_move();
        pulse_start();
        serve_moves(0, 1);
        start_tour = 1'b1;
        serve_leg(leg_cmd(mem[2], 1'b0), 8'hA5, 1'b1);
        start_tour = 1'b0;
        vectors++;
        if (mv_indx !== 5'd2) begin
            miscompares++;
            $display("FAIL start_ignored: mv_indx=%0d required 2", mv_indx);
        end
        do_reset();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h01;
        test_reset();
        test_passthrough();
        test_full_tour();
        test_bad_move();
        test_reset_mid_tour();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
